// File: rtl/axi4_sram_slave.sv
// AXI4 subordinate backed by a word-addressed SRAM, one transaction at a time.
// Supports INCR bursts (burst type ignored), byte strobes, ID echo,
// programmable read/write response latency and DECERR for unmapped beats.
// Ports:
//   clock, reset             - rising-edge clock, async active-low reset
//   io_slave_aw*             - write address channel
//   io_slave_w*              - write data channel
//   io_slave_b*              - write response channel
//   io_slave_ar*             - read address channel
//   io_slave_r*              - read data channel
module axi4_sram_slave #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned RD_LATENCY  = 1,
  parameter int unsigned WR_LATENCY  = 1
) (
  input  logic        clock,
  input  logic        reset,
  output logic        io_slave_awready,
  input  logic        io_slave_awvalid,
  input  logic [31:0] io_slave_awaddr,
  input  logic [3:0]  io_slave_awid,
  input  logic [7:0]  io_slave_awlen,
  input  logic [2:0]  io_slave_awsize,
  input  logic [1:0]  io_slave_awburst,
  output logic        io_slave_wready,
  input  logic        io_slave_wvalid,
  input  logic [31:0] io_slave_wdata,
  input  logic [3:0]  io_slave_wstrb,
  input  logic        io_slave_wlast,
  input  logic        io_slave_bready,
  output logic        io_slave_bvalid,
  output logic [1:0]  io_slave_bresp,
  output logic [3:0]  io_slave_bid,
  output logic        io_slave_arready,
  input  logic        io_slave_arvalid,
  input  logic [31:0] io_slave_araddr,
  input  logic [3:0]  io_slave_arid,
  input  logic [7:0]  io_slave_arlen,
  input  logic [2:0]  io_slave_arsize,
  input  logic [1:0]  io_slave_arburst,
  input  logic        io_slave_rready,
  output logic        io_slave_rvalid,
  output logic [1:0]  io_slave_rresp,
  output logic [31:0] io_slave_rdata,
  output logic        io_slave_rlast,
  output logic [3:0]  io_slave_rid
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE, S_RWAIT, S_RDATA, S_WDATA, S_WWAIT, S_WRESP
  } state_e;

  state_e            state_q, state_d;
  logic              ready_en_q;
  logic [31:0]       addr_q, addr_d;
  logic [3:0]        id_q, id_d;
  logic [7:0]        len_q, len_d;
  logic [2:0]        size_q, size_d;
  logic [7:0]        beat_q, beat_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_dec_q, err_dec_d;
  logic              err_len_q, err_len_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;

  logic [31:0]       mem_q [DEPTH_WORDS];

  logic              awready_c, arready_c, wready_c, mem_we_c;
  logic [31:0]       addr_step_c, addr_nxt_c;

  // Burst type is always treated as INCR.
  logic unused_burst_c;
  assign unused_burst_c = ^{io_slave_awburst, io_slave_arburst};

  // Address decode: below base or past the last word is unmapped.
  function automatic logic in_range(input logic [31:0] a);
    logic [31:0] off;
    off = a - ADDR_BASE;
    return (a >= ADDR_BASE) && ((off >> 2) < 32'(DEPTH_WORDS));
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - ADDR_BASE;
    return off[IDX_W+1:2];
  endfunction

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return in_range(a) ? mem_q[word_idx(a)] : 32'h0;
  endfunction

  function automatic logic [1:0] rd_resp(input logic [31:0] a);
    return in_range(a) ? 2'b00 : 2'b11;
  endfunction

  assign addr_step_c = 32'(1) << size_q;
  assign addr_nxt_c  = addr_q + addr_step_c;

  // State and transaction registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      ready_en_q <= 1'b0;
      addr_q     <= '0;
      id_q       <= '0;
      len_q      <= '0;
      size_q     <= '0;
      beat_q     <= '0;
      cnt_q      <= '0;
      err_dec_q  <= 1'b0;
      err_len_q  <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= '0;
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;
      addr_q     <= addr_d;
      id_q       <= id_d;
      len_q      <= len_d;
      size_q     <= size_d;
      beat_q     <= beat_d;
      cnt_q      <= cnt_d;
      err_dec_q  <= err_dec_d;
      err_len_q  <= err_len_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clock) begin
    if (mem_we_c) begin
      for (int b = 0; b < 4; b++) begin
        if (io_slave_wstrb[b]) mem_q[word_idx(addr_q)][8*b +: 8] <= io_slave_wdata[8*b +: 8];
      end
    end
  end

  // Next-state and handshake logic.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    id_d      = id_q;
    len_d     = len_q;
    size_d    = size_q;
    beat_d    = beat_q;
    cnt_d     = cnt_q;
    err_dec_d = err_dec_q;
    err_len_d = err_len_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    awready_c = 1'b0;
    arready_c = 1'b0;
    wready_c  = 1'b0;
    mem_we_c  = 1'b0;

    case (state_q)
      S_IDLE: begin
        awready_c = ready_en_q;
        arready_c = ready_en_q & ~io_slave_awvalid;
        if (io_slave_awvalid && awready_c) begin
          addr_d    = io_slave_awaddr;
          id_d      = io_slave_awid;
          len_d     = io_slave_awlen;
          size_d    = io_slave_awsize;
          beat_d    = '0;
          err_dec_d = 1'b0;
          err_len_d = 1'b0;
          state_d   = S_WDATA;
        end else if (io_slave_arvalid && arready_c) begin
          addr_d = io_slave_araddr;
          id_d   = io_slave_arid;
          len_d  = io_slave_arlen;
          size_d = io_slave_arsize;
          beat_d = '0;
          cnt_d  = CNT_W'(RD_LATENCY - 1);
          // A latency of one presents beat 0 in the cycle right after AR.
          if (RD_LATENCY <= 1) begin
            rdata_d = rd_word(io_slave_araddr);
            rresp_d = rd_resp(io_slave_araddr);
            state_d = S_RDATA;
          end else begin
            state_d = S_RWAIT;
          end
        end
      end

      S_RWAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          rdata_d = rd_word(addr_q);
          rresp_d = rd_resp(addr_q);
          state_d = S_RDATA;
        end
      end

      S_RDATA: begin
        if (io_slave_rready) begin
          if (beat_q == len_q) begin
            rdata_d = '0;
            rresp_d = '0;
            state_d = S_IDLE;
          end else begin
            addr_d  = addr_nxt_c;
            beat_d  = beat_q + 8'd1;
            rdata_d = rd_word(addr_nxt_c);
            rresp_d = rd_resp(addr_nxt_c);
          end
        end
      end

      S_WDATA: begin
        wready_c = 1'b1;
        if (io_slave_wvalid) begin
          mem_we_c = in_range(addr_q);
          if (!in_range(addr_q)) err_dec_d = 1'b1;
          addr_d = addr_nxt_c;
          beat_d = beat_q + 8'd1;
          if (io_slave_wlast) begin
            if (beat_q != len_q) err_len_d = 1'b1;
            cnt_d = CNT_W'(WR_LATENCY - 1);
            state_d = (WR_LATENCY <= 1) ? S_WRESP : S_WWAIT;
          end
        end
      end

      S_WWAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_WRESP;
      end

      S_WRESP: begin
        if (io_slave_bready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign io_slave_awready = awready_c;
  assign io_slave_arready = arready_c;
  assign io_slave_wready  = wready_c;

  assign io_slave_bvalid  = (state_q == S_WRESP);
  assign io_slave_bid     = (state_q == S_WRESP) ? id_q : 4'h0;
  assign io_slave_bresp   = (state_q != S_WRESP) ? 2'b00 :
                            err_dec_q            ? 2'b11 :
                            err_len_q            ? 2'b10 : 2'b00;

  assign io_slave_rvalid  = (state_q == S_RDATA);
  assign io_slave_rid     = (state_q == S_RDATA) ? id_q : 4'h0;
  assign io_slave_rlast   = (state_q == S_RDATA) && (beat_q == len_q);
  assign io_slave_rdata   = rdata_q;
  assign io_slave_rresp   = rresp_q;

endmodule

// File: tb/tb_axi4_sram_slave.sv
// Directed testbench for axi4_sram_slave: table of single write/read-back
// vectors plus hand-written burst, arbitration, length-error and reset cases.
module tb_axi4_sram_slave;

  logic        clk, rst_n;
  logic        awready, awvalid;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        wready, wvalid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bready, bvalid;
  logic [1:0]  bresp;
  logic [3:0]  bid;
  logic        arready, arvalid;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rready, rvalid;
  logic [1:0]  rresp;
  logic [31:0] rdata;
  logic        rlast;
  logic [3:0]  rid;

  int checks = 0;
  int fails  = 0;

  logic [31:0] exp_d [4];
  logic [1:0]  exp_r [4];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_bresp;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_rresp;
  } vec_t;

  vec_t vecs [8];

  axi4_sram_slave dut (
    .clock(clk), .reset(rst_n),
    .io_slave_awready(awready), .io_slave_awvalid(awvalid), .io_slave_awaddr(awaddr),
    .io_slave_awid(awid), .io_slave_awlen(awlen), .io_slave_awsize(awsize),
    .io_slave_awburst(awburst),
    .io_slave_wready(wready), .io_slave_wvalid(wvalid), .io_slave_wdata(wdata),
    .io_slave_wstrb(wstrb), .io_slave_wlast(wlast),
    .io_slave_bready(bready), .io_slave_bvalid(bvalid), .io_slave_bresp(bresp),
    .io_slave_bid(bid),
    .io_slave_arready(arready), .io_slave_arvalid(arvalid), .io_slave_araddr(araddr),
    .io_slave_arid(arid), .io_slave_arlen(arlen), .io_slave_arsize(arsize),
    .io_slave_arburst(arburst),
    .io_slave_rready(rready), .io_slave_rvalid(rvalid), .io_slave_rresp(rresp),
    .io_slave_rdata(rdata), .io_slave_rlast(rlast), .io_slave_rid(rid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Write burst: beat i carries data+i; wlast on beat nbeats-1.
  task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input int nbeats, input logic [31:0] data, input logic [3:0] strb,
                          output logic [1:0] br, output logic [3:0] bi);
    int t;
    @(negedge clk);
    awvalid = 1'b1; awaddr = addr; awid = id; awlen = len; awsize = 3'd2; awburst = 2'b01;
    #1; t = 0;
    while (!awready && t < 50) begin @(negedge clk); #1; t++; end
    if (!awready) chk("aw_timeout", 32'(awready), 32'd1);
    @(negedge clk);
    awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      wvalid = 1'b1; wdata = data + 32'(i); wstrb = strb; wlast = (i == nbeats - 1);
      #1; t = 0;
      while (!wready && t < 50) begin @(negedge clk); #1; t++; end
      if (!wready) chk("w_timeout", 32'(wready), 32'd1);
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    bready = 1'b1;
    #1; t = 0;
    while (!bvalid && t < 50) begin @(negedge clk); #1; t++; end
    if (!bvalid) chk("b_timeout", 32'(bvalid), 32'd1);
    br = bresp; bi = bid;
    @(negedge clk);
    bready = 1'b0;
  endtask

  // Read burst checked against exp_d/exp_r; rvalid must be up the cycle after AR.
  task automatic rd_burst(input string nm, input logic [31:0] addr, input logic [3:0] id,
                          input logic [7:0] len, input bit toggle);
    int t, beat, cyc;
    @(negedge clk);
    arvalid = 1'b1; araddr = addr; arid = id; arlen = len; arsize = 3'd2; arburst = 2'b01;
    #1; t = 0;
    while (!arready && t < 50) begin @(negedge clk); #1; t++; end
    if (!arready) chk({nm, "_ar_timeout"}, 32'(arready), 32'd1);
    @(negedge clk);
    arvalid = 1'b0;
    beat = 0; cyc = 0;
    while (beat <= int'(len) && cyc < 64) begin
      rready = toggle ? ((cyc % 2) == 0) : 1'b1;
      #1;
      chk($sformatf("%s_rvalid_c%0d", nm, cyc), 32'(rvalid), 32'd1);
      if (rvalid) begin
        chk($sformatf("%s_rdata_b%0d", nm, beat), rdata, exp_d[beat]);
        chk($sformatf("%s_rresp_b%0d", nm, beat), 32'(rresp), 32'(exp_r[beat]));
        chk($sformatf("%s_rid_b%0d", nm, beat), 32'(rid), 32'(id));
        chk($sformatf("%s_rlast_b%0d", nm, beat), 32'(rlast), 32'(beat == int'(len)));
        if (rready) beat++;
      end
      @(negedge clk);
      cyc++;
    end
    rready = 1'b0;
    #1;
    chk({nm, "_rvalid_after"}, 32'(rvalid), 32'd0);
  endtask

  initial begin
    logic [1:0] br;
    logic [3:0] bi;

    vecs[0] = '{32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'hDEAD_BEEF, 2'b00};
    vecs[1] = '{32'h8000_0020, 32'h1122_3344, 4'hF, 2'b00, 32'h1122_3344, 2'b00};
    vecs[2] = '{32'h8000_0020, 32'hAABB_CCDD, 4'h5, 2'b00, 32'h11BB_33DD, 2'b00};
    vecs[3] = '{32'h8000_0021, 32'h0000_EE00, 4'h2, 2'b00, 32'h11BB_EEDD, 2'b00};
    vecs[4] = '{32'h8000_4000, 32'h1234_5678, 4'hF, 2'b11, 32'h0000_0000, 2'b11};
    vecs[5] = '{32'h8000_0000, 32'hFFFF_FFFF, 4'h0, 2'b00, 32'hA5A5_0000, 2'b00};
    vecs[6] = '{32'h8000_3FFC, 32'hCAFE_F00D, 4'hF, 2'b00, 32'hCAFE_F00D, 2'b00};
    vecs[7] = '{32'h7FFF_FFFC, 32'h0BAD_F00D, 4'hF, 2'b11, 32'h0000_0000, 2'b11};

    rst_n = 1'b0;
    awvalid = 0; awaddr = 0; awid = 0; awlen = 0; awsize = 0; awburst = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
    arvalid = 0; araddr = 0; arid = 0; arlen = 0; arsize = 0; arburst = 0; rready = 0;

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_bresp_rresp_ids", {24'd0, bresp, rresp, bid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_awready_gap", 32'(awready), 32'd0);
    @(negedge clk);
    #1;
    chk("post_rst_awready_on", 32'(awready), 32'd1);

    // Preload words 0..3 with a burst.
    do_write(32'h8000_0000, 4'h1, 8'd3, 4, 32'hA5A5_0000, 4'hF, br, bi);
    chk("preload_bresp", 32'(br), 32'd0);
    chk("preload_bid", 32'(bi), 32'd1);

    // Table-driven single write / read-back.
    for (int i = 0; i < 8; i++) begin
      do_write(vecs[i].addr, 4'(i), 8'd0, 1, vecs[i].data, vecs[i].strb, br, bi);
      chk($sformatf("v%0d_bresp", i), 32'(br), 32'(vecs[i].exp_bresp));
      chk($sformatf("v%0d_bid", i), 32'(bi), 32'(i));
      exp_d[0] = vecs[i].exp_rdata;
      exp_r[0] = vecs[i].exp_rresp;
      rd_burst($sformatf("v%0d", i), vecs[i].addr, 4'(i + 8), 8'd0, 1'b0);
    end

    // Read burst with rready toggling.
    for (int i = 0; i < 4; i++) begin
      exp_d[i] = 32'hA5A5_0000 + 32'(i);
      exp_r[i] = 2'b00;
    end
    rd_burst("burst", 32'h8000_0000, 4'd5, 8'd3, 1'b1);

    // Burst straddling the bottom of the map.
    exp_d[0] = 32'h0;          exp_r[0] = 2'b11;
    exp_d[1] = 32'hA5A5_0000;  exp_r[1] = 2'b00;
    rd_burst("decerr", 32'h7FFF_FFFC, 4'd2, 8'd1, 1'b0);

    // Simultaneous AW and AR: write first, AR held off until B completes.
    @(negedge clk);
    awvalid = 1'b1; awaddr = 32'h8000_0040; awid = 4'd3; awlen = 8'd0; awsize = 3'd2;
    arvalid = 1'b1; araddr = 32'h8000_0040; arid = 4'd9; arlen = 8'd0; arsize = 3'd2;
    #1;
    chk("both_awready", 32'(awready), 32'd1);
    chk("both_arready_idle", 32'(arready), 32'd0);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b1; wdata = 32'h5555_AAAA; wstrb = 4'hF; wlast = 1'b1;
    #1;
    chk("both_wready", 32'(wready), 32'd1);
    chk("both_arready_wdata", 32'(arready), 32'd0);
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0;
    #1;
    chk("both_bvalid", 32'(bvalid), 32'd1);
    chk("both_bid", 32'(bid), 32'd3);
    chk("both_bresp", 32'(bresp), 32'd0);
    chk("both_arready_wresp", 32'(arready), 32'd0);
    @(negedge clk);
    bready = 1'b1;
    #1;
    chk("both_arready_bhs", 32'(arready), 32'd0);
    @(negedge clk);
    bready = 1'b0;
    #1;
    chk("both_arready_after", 32'(arready), 32'd1);
    @(negedge clk);
    arvalid = 1'b0; rready = 1'b1;
    #1;
    chk("both_rvalid", 32'(rvalid), 32'd1);
    chk("both_rdata", rdata, 32'h5555_AAAA);
    chk("both_rid", 32'(rid), 32'd9);
    chk("both_rlast", 32'(rlast), 32'd1);
    @(negedge clk);
    rready = 1'b0;
    #1;
    chk("both_rvalid_done", 32'(rvalid), 32'd0);

    // Early wlast: awlen 3 but wlast on beat 1.
    do_write(32'h8000_0100, 4'd7, 8'd3, 2, 32'h0000_0100, 4'hF, br, bi);
    chk("short_bresp", 32'(br), 32'd2);
    chk("short_bid", 32'(bi), 32'd7);

    // Reset during beat 2 of a read burst.
    @(negedge clk);
    arvalid = 1'b1; araddr = 32'h8000_0000; arid = 4'd4; arlen = 8'd3; arsize = 3'd2;
    #1;
    chk("rst_seq_arready", 32'(arready), 32'd1);
    @(negedge clk);
    arvalid = 1'b0; rready = 1'b1;
    #1;
    chk("rst_seq_b0", rdata, 32'hA5A5_0000);
    @(negedge clk);
    #1;
    chk("rst_seq_b1", rdata, 32'hA5A5_0001);
    @(negedge clk);
    rready = 1'b0;
    #1;
    chk("rst_seq_b2", rdata, 32'hA5A5_0002);
    chk("rst_seq_b2_valid", 32'(rvalid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_seq_rvalid_async", 32'(rvalid), 32'd0);
    chk("rst_seq_rdata_async", rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    arvalid = 1'b1; araddr = 32'h8000_0010; arid = 4'd6; arlen = 8'd0; arsize = 3'd2;
    #1;
    chk("rst_seq_arready_gap", 32'(arready), 32'd0);
    chk("rst_seq_awready_gap", 32'(awready), 32'd0);
    @(negedge clk);
    #1;
    chk("rst_seq_arready_on", 32'(arready), 32'd1);
    @(negedge clk);
    arvalid = 1'b0; rready = 1'b1;
    #1;
    chk("rst_seq_new_rvalid", 32'(rvalid), 32'd1);
    chk("rst_seq_new_rdata", rdata, 32'hDEAD_BEEF);
    chk("rst_seq_new_rid", 32'(rid), 32'd6);
    @(negedge clk);
    rready = 1'b0;
    #1;
    chk("rst_seq_new_done", 32'(rvalid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/axi4_sram_slave.md
Name: axi4_sram_slave

Overview:
- AXI4 subordinate (responder) backing the CPU core's AXI4 master port in simulation and FPGA builds.
- Internal word-addressed SRAM, handles one transaction at a time.
- Supports INCR read and write bursts, byte strobes, ID echo, programmable response latency and decode errors for out-of-range addresses.

Parameters:
- ADDR_BASE, 32'h80000000, byte address of word 0.
- DEPTH_WORDS, 4096, number of 32-bit words; power of two.
- RD_LATENCY, 1, cycles from AR handshake to first rvalid; minimum 1.
- WR_LATENCY, 1, cycles from the final W beat to bvalid; minimum 1.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- io_slave_awready out 1; awvalid in 1; awaddr in 32; awid in 4; awlen in 8; awsize in 3; awburst in 2.
- io_slave_wready out 1; wvalid in 1; wdata in 32; wstrb in 4; wlast in 1.
- io_slave_bready in 1; bvalid out 1; bresp out 2; bid out 4.
- io_slave_arready out 1; arvalid in 1; araddr in 32; arid in 4; arlen in 8; arsize in 3; arburst in 2.
- io_slave_rready in 1; rvalid out 1; rresp out 2; rdata out 32; rlast out 1; rid out 4.

Behaviour:
- Reset (reset low, async):
  - State goes to IDLE.
  - All valid/ready outputs are 0; bresp, rresp, rdata, bid, rid are 0.
  - The ready_en register clears. It sets on the first clock edge after reset deasserts.
  - Reset mid-transaction abandons the transaction. No response is issued.
- States: IDLE, RWAIT, RDATA, WDATA, WWAIT, WRESP.
- IDLE:
  - awready = ready_en.
  - arready = ready_en & ~awvalid. Write wins when both are valid in the same cycle.
  - AW handshake: latch awaddr, awid, awlen, awsize; clear the beat counter and error flag; go to WDATA.
  - AR handshake: latch araddr, arid, arlen, arsize; load the latency counter with RD_LATENCY-1; go to RWAIT.
- RWAIT:
  - Decrement the counter. At 0, go to RDATA with beat 0 presented.
  - With RD_LATENCY=1, rvalid rises the cycle after the AR handshake.
- RDATA:
  - rvalid = 1, rid = latched id, rlast = (beat == arlen).
  - rdata and rresp hold stable while rvalid & ~rready.
  - Each rready handshake advances the address by (1 << arsize) and increments the beat.
  - After the last-beat handshake, go to IDLE. arready is not asserted in the same cycle.
- WDATA:
  - wready = 1.
  - Each handshake writes the byte lanes enabled by wstrb at the current address, advances the address by (1 << awsize), and increments the beat.
  - wlast handshake goes to WWAIT and loads the counter with WR_LATENCY-1.
  - If wlast arrives with beat ≠ awlen, set the length-error flag. A burst ends only on wlast.
- WWAIT: count down, then go to WRESP.
- WRESP:
  - bvalid = 1, bid = latched awid.
  - bresp = 2'b11 if any beat was out of range; else 2'b10 on length error; else 2'b00.
  - Hold until bready, then go to IDLE.
- Decode:
  - Word index = (addr - ADDR_BASE) >> 2.
  - In range iff addr >= ADDR_BASE and index < DEPTH_WORDS.
  - Out-of-range read beat: rdata = 0, rresp = 2'b11. Other beats are unaffected.
  - Out-of-range write beat: data dropped, DECERR flag set.
  - Narrow sizes access the containing aligned word; lanes are selected by wstrb only.
- awburst/arburst are treated as INCR regardless of value.
- Address arithmetic is 32-bit and wraps modulo 2^32; the wrapped address then decodes out of range.
- Memory contents after reset are undefined. Storage is not cleared by reset.

Test Plan:
- Single write then read: AW 0x80000010 len 0, W 0xDEADBEEF strb 4'hF → bresp 0, bid echoed. AR same address → rdata 0xDEADBEEF, rlast 1, rresp 0, rvalid exactly 1 cycle after AR with RD_LATENCY=1.
- Byte strobe: write 0x11223344 strb F, then 0xAABBCCDD strb 4'b0101 → read returns 0x11BB33DD.
- Read burst with backpressure: AR 0x80000000 len 3, arid 5 after preloading words 0..3. rready toggles 1,0,1,0… → four beats in order, rid 5, rlast only on beat 3, data stable during stalls.
- Decode error: AR 0x7FFFFFFC len 1 → beat0 rresp 2'b11 rdata 0, beat1 (0x80000000) rresp 0. Write to ADDR_BASE+4*DEPTH_WORDS → bresp 2'b11, memory unchanged.
- Simultaneous AW/AR in IDLE → write is serviced first, arready stays 0 until the write response completes. wlast on beat 1 of an awlen=3 burst → bresp 2'b10.
- Reset asserted during RDATA beat 2 → rvalid drops asynchronously. After release, ready outputs are 0 for one cycle, then a new AR is accepted.
